// File: rtl/riscv_wb.sv
// RISC-V writeback stage: completes data-memory accesses, forms load data and drives register-file writes.
// Optional data-memory watchdog enabled by defining RISCV_WB_DMEM_TIMEOUT_EN.
module riscv_wb #(
    parameter int unsigned     XLEN           = 64,
    parameter int unsigned     ILEN           = 64,
    parameter int unsigned     EXCEPTION_SIZE = 16,
    parameter logic [XLEN-1:0] PC_INIT        = 'h8000_0000,
    parameter int unsigned     DMEM_TIMEOUT   = 255
) (
    input  logic                      clk,
    input  logic                      rstn,

    input  logic [XLEN-1:0]           mem_pc,
    input  logic [ILEN-1:0]           mem_instr,
    input  logic                      mem_bubble,
    input  logic [EXCEPTION_SIZE-1:0] mem_exception,
    input  logic [XLEN-1:0]           mem_r,
    input  logic [XLEN-1:0]           mem_memadr,

    input  logic                      dmem_ack,
    input  logic                      dmem_err,
    input  logic [XLEN-1:0]           dmem_q,

    output logic                      wb_stall,
    output logic [XLEN-1:0]           wb_pc,
    output logic [ILEN-1:0]           wb_instr,
    output logic                      wb_bubble,
    output logic [EXCEPTION_SIZE-1:0] wb_exception,
    output logic [XLEN-1:0]           wb_badaddr,

    output logic                      wb_we,
    output logic [4:0]                wb_dst,
    output logic [XLEN-1:0]           wb_r
);

    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_OPIMM32  = 7'b0011011;
    localparam logic [6:0] OPC_OP32     = 7'b0111011;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    logic [6:0]                opcode;
    logic [2:0]                funct3;
    logic                      is_load;
    logic                      is_store;
    logic                      is_access;
    logic                      misaligned;
    logic                      aligned_access;
    logic                      bus_err;
    logic                      flush;
    logic                      we_op;
    logic                      we_next;
    logic [EXCEPTION_SIZE-1:0] fault;
    logic [EXCEPTION_SIZE-1:0] exc_next;
    logic [XLEN-1:0]           shifted;
    logic [XLEN-1:0]           load_data;

    assign opcode    = mem_instr[6:0];
    assign funct3    = mem_instr[14:12];
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_access = !mem_bubble && (mem_exception == '0) && (is_load || is_store);

    always_comb begin
        misaligned = 1'b0;
        unique case (funct3[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = mem_memadr[0];
            2'b10:   misaligned = |mem_memadr[1:0];
            default: misaligned = |mem_memadr[2:0];
        endcase
    end

    assign aligned_access = is_access && !misaligned;

`ifdef RISCV_WB_DMEM_TIMEOUT_EN
    localparam int unsigned WDW = ($clog2(DMEM_TIMEOUT + 1) > 8) ? $clog2(DMEM_TIMEOUT + 1) : 8;

    logic [WDW-1:0] watchdog;
    logic           timeout;

    assign timeout = (watchdog == WDW'(DMEM_TIMEOUT));
    assign bus_err = aligned_access && (dmem_err || timeout);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn)
            watchdog <= '0;
        else if (wb_stall)
            watchdog <= watchdog + WDW'(1);
        else
            watchdog <= '0;
    end
`else
    assign bus_err = aligned_access && dmem_err;
`endif

    // An error (real or watchdog) completes the access even when ack is also high.
    assign wb_stall = aligned_access && !dmem_ack && !bus_err;

    always_comb begin
        fault = '0;
        if (is_access && misaligned)
            fault[is_store ? 6 : 4] = 1'b1;
        else if (bus_err)
            fault[is_store ? 7 : 5] = 1'b1;
    end

    assign exc_next = mem_exception | fault;

    always_comb begin
        shifted   = dmem_q >> {mem_memadr[2:0], 3'b000};
        load_data = shifted;
        unique case (funct3)
            3'b000:  load_data = {{(XLEN-8){shifted[7]}},   shifted[7:0]};
            3'b001:  load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
            3'b010:  load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
            3'b100:  load_data = {{(XLEN-8){1'b0}},         shifted[7:0]};
            3'b101:  load_data = {{(XLEN-16){1'b0}},        shifted[15:0]};
            3'b110:  load_data = {{(XLEN-32){1'b0}},        shifted[31:0]};
            default: load_data = shifted;
        endcase
    end

    always_comb begin
        we_op = 1'b0;
        unique case (opcode)
            OPC_LOAD, OPC_OPIMM, OPC_OP, OPC_LUI, OPC_AUIPC,
            OPC_JAL, OPC_JALR, OPC_OPIMM32, OPC_OP32: we_op = 1'b1;
            OPC_SYSTEM: we_op = (funct3 != 3'b000);
            default:    we_op = 1'b0;
        endcase
    end

    assign we_next = !mem_bubble && (exc_next == '0) && (mem_instr[11:7] != 5'd0) && we_op;

    // A registered exception forces one bubble so it is visible for a single cycle.
    assign flush = (wb_exception != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wb_pc        <= PC_INIT;
            wb_instr     <= '0;
            wb_bubble    <= 1'b1;
            wb_exception <= '0;
            wb_badaddr   <= '0;
            wb_we        <= 1'b0;
            wb_dst       <= '0;
            wb_r         <= '0;
        end else if (wb_stall || flush) begin
            wb_bubble    <= 1'b1;
            wb_we        <= 1'b0;
            wb_exception <= '0;
        end else begin
            wb_pc        <= mem_pc;
            wb_instr     <= mem_instr;
            wb_bubble    <= mem_bubble;
            wb_exception <= exc_next;
            wb_we        <= we_next;
            wb_dst       <= mem_instr[11:7];
            wb_r         <= is_load ? load_data : mem_r;
            if (fault != '0)
                wb_badaddr <= mem_memadr;
        end
    end

endmodule

// File: tb/tb_riscv_wb.sv
// Scoreboard bench for riscv_wb: random and directed instructions checked against a behavioural model.
module tb_riscv_wb;

    localparam int unsigned XLEN = 64;
    localparam int unsigned ILEN = 64;
    localparam int unsigned ES   = 16;
    localparam logic [63:0] PCI  = 64'h8000_0000;
    localparam int unsigned TO   = 4;

    localparam logic [6:0] LOAD  = 7'b0000011, STORE  = 7'b0100011, OPIMM = 7'b0010011;
    localparam logic [6:0] OP    = 7'b0110011, LUI    = 7'b0110111, AUIPC = 7'b0010111;
    localparam logic [6:0] JAL   = 7'b1101111, JALR   = 7'b1100111, OPIMM32 = 7'b0011011;
    localparam logic [6:0] OP32  = 7'b0111011, SYSTEM = 7'b1110011;
    localparam logic [6:0] FENCE = 7'b0001111, BRANCH = 7'b1100011;

    logic            clk, rstn;
    logic [63:0]     mem_pc, mem_instr, mem_r, mem_memadr, dmem_q;
    logic            mem_bubble, dmem_ack, dmem_err;
    logic [ES-1:0]   mem_exception;
    logic            wb_stall, wb_bubble, wb_we;
    logic [63:0]     wb_pc, wb_instr, wb_badaddr, wb_r;
    logic [ES-1:0]   wb_exception;
    logic [4:0]      wb_dst;

    riscv_wb #(
        .XLEN(XLEN), .ILEN(ILEN), .EXCEPTION_SIZE(ES), .PC_INIT(PCI), .DMEM_TIMEOUT(TO)
    ) dut (
        .clk(clk), .rstn(rstn),
        .mem_pc(mem_pc), .mem_instr(mem_instr), .mem_bubble(mem_bubble),
        .mem_exception(mem_exception), .mem_r(mem_r), .mem_memadr(mem_memadr),
        .dmem_ack(dmem_ack), .dmem_err(dmem_err), .dmem_q(dmem_q),
        .wb_stall(wb_stall), .wb_pc(wb_pc), .wb_instr(wb_instr), .wb_bubble(wb_bubble),
        .wb_exception(wb_exception), .wb_badaddr(wb_badaddr),
        .wb_we(wb_we), .wb_dst(wb_dst), .wb_r(wb_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] pc, instr, r, badaddr;
        logic [15:0] exc;
        logic        we;
        logic [4:0]  dst;
        logic        chk_r, chk_bad;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;
    logic prev_fault = 1'b0;
    logic mon_prev_exc = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int unsigned acc_bytes(input logic [2:0] f3);
        return 32'd1 << (f3 % 4);
    endfunction

    // Reference load: pick the addressed bytes arithmetically, then extend by signedness.
    function automatic logic [63:0] load_val(input logic [2:0] f3, input logic [63:0] adr,
                                             input logic [63:0] q);
        int unsigned n;
        logic [63:0] mask, v;
        n    = acc_bytes(f3);
        mask = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
        v    = (q >> (8 * (adr % 8))) & mask;
        if (f3 < 3'd4 && n < 8 && v[8 * n - 1])
            v = v | ~mask;
        return v;
    endfunction

    function automatic logic writes_rd(input logic [6:0] opc, input logic [2:0] f3);
        if (opc == SYSTEM) return f3 != 3'd0;
        return opc inside {LOAD, OPIMM, OP, LUI, AUIPC, JAL, JALR, OPIMM32, OP32};
    endfunction

    function automatic logic [63:0] mk(input logic [6:0] opc, input logic [2:0] f3, input logic [4:0] rd);
        logic [63:0] v;
        v = {$urandom(), $urandom()};
        v[6:0]   = opc;
        v[11:7]  = rd;
        v[14:12] = f3;
        return v;
    endfunction

    // Present one instruction starting just after a rising edge; an access with neither
    // ack nor err at the end is expected to complete through the memory watchdog.
    task automatic issue(input logic [63:0] pc, input logic [63:0] instr, input logic bub,
                         input logic [15:0] mexc, input logic [63:0] r, input logic [63:0] adr,
                         input logic [63:0] q, input int unsigned delay,
                         input logic ack_end, input logic err_end);
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        is_acc, mis, waits, st, dropped;
        logic [15:0] fault, exc;
        exp_t        e;
        opc    = instr[6:0];
        f3     = instr[14:12];
        st     = (opc == STORE);
        is_acc = !bub && mexc == 16'd0 && (opc == LOAD || st);
        mis    = is_acc && ((adr % acc_bytes(f3)) != 0);
        waits  = is_acc && !mis;
        fault  = 16'd0;
        if (mis)
            fault = st ? 16'h0040 : 16'h0010;
        else if (waits && (err_end || !ack_end))
            fault = st ? 16'h0080 : 16'h0020;

        mem_pc = pc; mem_instr = instr; mem_bubble = bub; mem_exception = mexc;
        mem_r = r; mem_memadr = adr; dmem_q = q;
        if (waits) begin
            dmem_ack = 1'b0; dmem_err = 1'b0;
            for (int k = 0; k < int'(delay); k++) begin
                #1;
                chk("stall_wait", 64'(wb_stall), 64'd1);
                if (k > 0) chk("bubble_wait", 64'(wb_bubble), 64'd1);
                @(posedge clk); #1;
            end
        end
        dmem_ack = ack_end; dmem_err = err_end;
        #1;
        chk("stall_done", 64'(wb_stall), 64'd0);

        dropped = prev_fault && (!waits || delay == 0);
        exc     = mexc | fault;
        if (!bub && !dropped) begin
            e.pc      = pc;
            e.instr   = instr;
            e.exc     = exc;
            e.we      = (exc == 16'd0) && (instr[11:7] != 5'd0) && writes_rd(opc, f3);
            e.dst     = instr[11:7];
            e.r       = (opc == LOAD) ? load_val(f3, adr, q) : r;
            e.chk_r   = (exc == 16'd0);
            e.badaddr = adr;
            e.chk_bad = (fault != 16'd0);
            sb.push_back(e);
        end
        prev_fault = !bub && !dropped && exc != 16'd0;
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rstn) begin
            mon_prev_exc = 1'b0;
        end else begin
            if (mon_prev_exc) begin
                chk("flush_bubble", 64'(wb_bubble), 64'd1);
                chk("flush_exc", 64'(wb_exception), 64'd0);
            end
            if (!wb_bubble) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_out actual_pc=%h required=no_output", wb_pc);
                end else begin
                    e = sb.pop_front();
                    chk("wb_pc", wb_pc, e.pc);
                    chk("wb_instr", wb_instr, e.instr);
                    chk("wb_exception", 64'(wb_exception), 64'(e.exc));
                    chk("wb_we", 64'(wb_we), 64'(e.we));
                    chk("wb_dst", 64'(wb_dst), 64'(e.dst));
                    if (e.chk_r)   chk("wb_r", wb_r, e.r);
                    if (e.chk_bad) chk("wb_badaddr", wb_badaddr, e.badaddr);
                end
            end
            mon_prev_exc = (wb_exception != '0);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "bench time limit");
    end

    initial begin : stim
        logic [63:0] q, adr, pc;
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic        bub, err_e, ack_e;
        logic [15:0] mexc;
        int unsigned sel;
        logic [6:0]  others [0:8];
        others = '{OPIMM, OP, LUI, AUIPC, JAL, JALR, OPIMM32, OP32, SYSTEM};

        rstn = 1'b0;
        mem_pc = '0; mem_instr = '0; mem_bubble = 1'b1; mem_exception = '0;
        mem_r = '0; mem_memadr = '0; dmem_ack = 1'b0; dmem_err = 1'b0; dmem_q = '0;
        #12;
        chk("rst_pc", wb_pc, PCI);
        chk("rst_bubble", 64'(wb_bubble), 64'd1);
        chk("rst_we", 64'(wb_we), 64'd0);
        chk("rst_exc", 64'(wb_exception), 64'd0);
        chk("rst_badaddr", wb_badaddr, 64'd0);
        #10 rstn = 1'b1;
        @(posedge clk); #1;

        q = 64'h8877_6655_4433_2211;
        issue(64'h100, mk(LOAD, 3'b000, 5'd5), 1'b0, 16'd0, 64'd0, 64'h1000_0007, q, 0, 1'b1, 1'b0);
        issue(64'h104, mk(LOAD, 3'b110, 5'd6), 1'b0, 16'd0, 64'd0, 64'h1000_0004, q, 3, 1'b1, 1'b0);
        issue(64'h108, mk(LOAD, 3'b001, 5'd7), 1'b0, 16'd0, 64'd0, 64'h1000_0001, q, 0, 1'b0, 1'b0);
        issue(64'h10c, mk(OPIMM, 3'b000, 5'd8), 1'b0, 16'd0, 64'h1234, 64'd0, q, 0, 1'b0, 1'b0);
        issue(64'h110, mk(STORE, 3'b011, 5'd9), 1'b0, 16'd0, 64'd0, 64'h2000_0008, q, 0, 1'b1, 1'b1);
        issue(64'h114, mk(OPIMM, 3'b000, 5'd10), 1'b0, 16'd0, 64'h55, 64'd0, q, 0, 1'b0, 1'b0);
        issue(64'h118, mk(OP, 3'b000, 5'd0), 1'b0, 16'd0, 64'h77, 64'd0, q, 0, 1'b1, 1'b1);
`ifdef RISCV_WB_DMEM_TIMEOUT_EN
        issue(64'h11c, mk(LOAD, 3'b011, 5'd11), 1'b0, 16'd0, 64'd0, 64'h3000_0010, q, TO, 1'b0, 1'b0);
        issue(64'h120, mk(OPIMM, 3'b000, 5'd12), 1'b0, 16'd0, 64'h99, 64'd0, q, 0, 1'b0, 1'b0);
`endif

        for (int n = 0; n < 300; n++) begin
            sel = $urandom_range(0, 19);
            if (sel < 6)       opc = LOAD;
            else if (sel < 10) opc = STORE;
            else if (sel == 10) opc = FENCE;
            else if (sel == 11) opc = BRANCH;
            else               opc = others[$urandom_range(0, 8)];
            if (opc == LOAD)       f3 = 3'($urandom_range(0, 6));
            else if (opc == STORE) f3 = 3'($urandom_range(0, 3));
            else                   f3 = 3'($urandom_range(0, 7));
            bub   = ($urandom_range(0, 9) == 0);
            mexc  = (!bub && $urandom_range(0, 14) == 0) ? 16'(32'd1 << $urandom_range(0, 15)) : 16'd0;
            adr   = {$urandom(), $urandom()};
            if ($urandom_range(0, 1) == 1) adr[2:0] = 3'b000;
            pc    = {$urandom(), $urandom()} & ~64'd3;
            err_e = ($urandom_range(0, 7) == 0);
            ack_e = err_e ? 1'($urandom_range(0, 1)) : 1'b1;
            issue(pc, mk(opc, f3, 5'($urandom_range(0, 31))), bub, mexc, {$urandom(), $urandom()},
                  adr, {$urandom(), $urandom()}, $urandom_range(0, 3), ack_e, err_e);
        end

        // Reset in the middle of a stalled doubleword load; a late ack must be ignored.
        mem_pc = 64'h200; mem_instr = mk(LOAD, 3'b011, 5'd3); mem_bubble = 1'b0;
        mem_exception = '0; mem_memadr = 64'h4000_0000; dmem_ack = 1'b0; dmem_err = 1'b0;
        #1 chk("rst_stall_before", 64'(wb_stall), 64'd1);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("rst2_bubble", 64'(wb_bubble), 64'd1);
        chk("rst2_pc", wb_pc, PCI);
        chk("rst2_we", 64'(wb_we), 64'd0);
        chk("rst2_exc", 64'(wb_exception), 64'd0);
        @(posedge clk); #1;
        mem_bubble = 1'b1; dmem_ack = 1'b1;
        prev_fault = 1'b0;
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rst2_stall_after", 64'(wb_stall), 64'd0);
        chk("rst2_bubble_after", 64'(wb_bubble), 64'd1);
        dmem_ack = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/riscv_wb.md
RISCV_WB -- requirements
Module: riscv_wb

Interface
REQ-001 The module SHALL have parameter XLEN, default 64, meaning data and address width.
REQ-002 The module SHALL have parameter ILEN, default 64, meaning instruction width.
REQ-003 The module SHALL have parameter EXCEPTION_SIZE, default 16, meaning exception vector width.
REQ-004 The module SHALL have parameter PC_INIT, default 'h8000_0000, meaning the wb_pc reset value.
REQ-005 The module SHALL have parameter DMEM_TIMEOUT, default 255, meaning the watchdog limit in cycles (used only with REQ-026).
REQ-006 The clock and reset SHALL be: one clock; reset is asynchronous and active-low (clk input 1 rising-edge clock; rstn input 1 active-low asynchronous reset).
REQ-007 The memory-stage inputs SHALL be: mem_pc in XLEN; mem_instr in ILEN; mem_bubble in 1; mem_exception in EXCEPTION_SIZE; mem_r in XLEN (ALU/CSR result); mem_memadr in XLEN (data address).
REQ-008 The data-memory inputs SHALL be: dmem_ack in 1 (access complete); dmem_err in 1 (bus error); dmem_q in XLEN (read data, aligned doubleword).
REQ-009 The pipeline outputs SHALL be: wb_stall out 1 (stalls all earlier stages); wb_pc out XLEN; wb_instr out ILEN; wb_bubble out 1; wb_exception out EXCEPTION_SIZE; wb_badaddr out XLEN.
REQ-010 The register-file outputs SHALL be: wb_we out 1; wb_dst out 5; wb_r out XLEN.

Function
REQ-011 An access SHALL be: mem_bubble=0, mem_exception=0, and opcode mem_instr[6:0] equal to LOAD 0000011 or STORE 0100011.
REQ-012 Misalignment SHALL be decoded from funct3[1:0] and mem_memadr[2:0]: H needs addr[0]=0; W needs addr[1:0]=0; D needs addr[2:0]=0.
REQ-013 A misaligned access SHALL NOT wait for dmem_ack. It SHALL set exception bit 4 (load) or bit 6 (store), and wb_badaddr SHALL be mem_memadr.
REQ-014 wb_stall SHALL be combinational: 1 iff an aligned access is present and dmem_ack=0 and dmem_err=0.
REQ-015 dmem_ack or dmem_err while no aligned access is pending SHALL be ignored.
REQ-016 When dmem_ack and dmem_err are both 1, dmem_err SHALL win.
REQ-017 dmem_err SHALL set exception bit 5 (load) or bit 7 (store), and wb_badaddr SHALL be mem_memadr.
REQ-018 All outputs except wb_stall SHALL be registered, with 1-cycle latency from the completing cycle.
REQ-019 While wb_stall=1, the module SHALL register wb_bubble=1, wb_we=0 and wb_exception=0. wb_pc, wb_instr and wb_r SHALL hold.
REQ-020 When not stalled, the module SHALL register:
  - wb_pc=mem_pc, wb_instr=mem_instr, wb_bubble=mem_bubble, wb_dst=mem_instr[11:7];
  - wb_exception = mem_exception OR the new fault bits.
REQ-021 Load data SHALL be formed as follows:
  - shift dmem_q right by 8*mem_memadr[2:0];
  - extract by funct3: LB 000, LH 001, LW 010, LD 011, LBU 100, LHU 101, LWU 110;
  - sign-extend for LB/LH/LW, zero-extend for the unsigned forms.
REQ-022 wb_r SHALL be the load data for LOAD, else mem_r.
REQ-023 wb_we SHALL be 1 only when all of the following hold:
  - not bubble, no exception, wb_dst≠0;
  - opcode is one of LOAD, OP-IMM, OP, LUI, AUIPC, JAL, JALR, OP-IMM-32, OP-32, or SYSTEM with funct3≠000.
REQ-024 The cycle after wb_exception≠0, the stage SHALL register a bubble, so the exception is presented for exactly one cycle.

Reset
REQ-025 On rstn=0, asynchronously and for all cycles while low, the module SHALL drive:
  - wb_pc=PC_INIT, wb_bubble=1, wb_we=0, wb_exception=0, wb_badaddr=0, watchdog=0;
  - wb_instr, wb_r and wb_dst are don't-care;
  - a pending access SHALL be abandoned, and a late dmem_ack after release SHALL be ignored per REQ-015.

Configuration
REQ-026 With macro RISCV_WB_DMEM_TIMEOUT_EN defined:
  - an 8+-bit watchdog SHALL count stalled cycles;
  - on reaching DMEM_TIMEOUT it SHALL act as dmem_err (REQ-017) and clear;
  - it SHALL clear on any non-stalled cycle.
  Undefined, no watchdog SHALL exist and wb_stall MAY persist indefinitely.

Verification
REQ-027 LB at addr ...7, dmem_q=64'h8877_6655_4433_2211, ack same cycle -> wb_r=64'hFFFF_FFFF_FFFF_FF88, wb_we=1, wb_stall=0.
REQ-028 LWU at addr ...4, ack after 3 cycles -> wb_stall=1 for 3 cycles, wb_bubble=1 meanwhile, then wb_r=64'h0000_0000_8877_6655.
REQ-029 LH at addr ...1 -> no wait, wb_exception[4]=1, wb_badaddr=addr, wb_we=0, next cycle wb_bubble=1.
REQ-030 SD with dmem_ack=1 and dmem_err=1 in the same cycle -> wb_exception[7]=1, wb_we=0.
REQ-031 rstn low during a stalled LD -> wb_bubble=1, wb_pc=PC_INIT, wb_stall=0 after release with no new access.
REQ-032 With RISCV_WB_DMEM_TIMEOUT_EN, DMEM_TIMEOUT=4 and LD with no ack -> wb_stall=1 for 4 cycles, then wb_exception[5]=1.
